adxl362_spi_slave: RTL and testbench
====================================

# adxl362_spi_slave

Synthesizable SPI-slave register model of the ADXL362 3-axis accelerometer. It sits on the board side of the SoC's SPI master (SCLK/MOSI/nCS/MISO) and answers the ADXL362 register protocol. It drives the INT1/INT2 interrupt pins. Acceleration and temperature values are fixed by parameters, so firmware drivers can be checked against known data.

## Interface
- X_VAL, 12'h010, X-axis sample, 12-bit two's complement
- Y_VAL, 12'h020, Y-axis sample
- Z_VAL, 12'h3F0, Z-axis sample
- T_VAL, 12'h000, temperature sample
- SCLK  input  1  SPI clock and block clock; mode 0 (CPOL=0, CPHA=0)
- reset  input  1  reset, asynchronous, active-high; restores all register defaults
- nCS  input  1  chip select, active-low; high asynchronously clears the transaction state
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first; 0 while nCS is high
- INT1  output  1  interrupt 1
- INT2  output  1  interrupt 2

## Operation
- Each transaction is framed by nCS low. Byte 0 is the command, byte 1 the address, bytes 2 and later are data. The address auto-increments after every data byte and wraps 0xFF->0x00.
- Commands:
  - 0x0A: register write.
  - 0x0B: register read.
  - 0x0D: FIFO read; returns 0x00 for every byte, and the address byte is not used.
  - Any other command: ignored, MISO stays 0.
- Read-only registers and their values:
  - 0x00 DEVID_AD=0xAD, 0x01 DEVID_MST=0x1D, 0x02 PARTID=0xF2, 0x03 REVID=0x01.
  - 0x08/0x09/0x0A = X/Y/Z_VAL[11:4].
  - 0x0B STATUS: bit6 AWAKE=1; bit0 DATA_READY=1 when POWER_CTL[1:0]==2'b10; other bits 0.
  - 0x0C/0x0D FIFO entries = 0x00.
  - 0x0E/0x0F = X_VAL low byte, then {4{X_VAL[11]}, X_VAL[11:8]}. Same layout at 0x10/0x11 for Y, 0x12/0x13 for Z, 0x14/0x15 for T.
- Read/write registers, default 0x00 unless stated: 0x1F SOFT_RESET, 0x20-0x29 threshold/timing, 0x2A INTMAP1, 0x2B INTMAP2, 0x2C FILTER_CTL (default 0x13), 0x2D POWER_CTL, 0x2E SELF_TEST.
- Writes to read-only or unimplemented addresses are discarded. Reads of unimplemented addresses return 0x00.
- Writing 0x52 to 0x1F restores all registers to their defaults when that byte completes. SOFT_RESET itself reads back 0x00.
- Interrupt outputs:
  - INT1 = (|(STATUS[6:0] & INTMAP1[6:0])) ^ INTMAP1[7], where bit7 is INT_LOW (active-low polarity).
  - INT2 uses the same formula with INTMAP2.
  - Both are combinational from the registers.

## Timing
- MOSI is sampled on the SCLK rising edge. MISO changes on the SCLK falling edge.
- A byte completes on its 8th rising edge.
- Writes: a data byte is stored on its 8th rising edge.
- Reads:
  - The register value at the current address is captured into the shift register at the end of the address byte and at the end of each data byte.
  - Its MSB appears on MISO at the next falling edge, and the remaining bits follow on successive falling edges.
- nCS high mid-byte aborts the transaction: the partial byte is discarded, no write happens, and the next nCS low restarts at byte 0.
- reset (asynchronous): registers return to defaults, MISO=0, bit/byte counters cleared.
  - Interrupt outputs after reset: INT1=INT2=0, because the INTMAPs are 0.
- reset has priority over any transaction in progress.

## Test plan
- After reset, read 0x00 with a 4-byte burst (0x0B,0x00,...) -> MISO returns 0xAD, 0x1D, 0xF2.
- Write 0x02 to 0x2D, then read 0x0B -> 0x41. Write 0x00 to 0x2D, then read 0x0B -> 0x40.
- Burst read from 0x0E with defaults -> 0x10, 0x00, 0x20, 0x00, 0xF0, 0x03. Read 0x08 -> 0x01.
- Write 0x01 to 0x2A with 0x2D=0x02 -> INT1=1. Write 0x81 to 0x2A -> INT1=0. INT2 stays 0.
- Write 0x55 to 0x2C, then 0x52 to 0x1F, then read 0x2C -> 0x13.
- Deassert nCS after 4 bits of a write data byte to 0x2E -> 0x2E still reads 0x00. Assert reset mid-read -> MISO=0 immediately.

Source files
------------

// File: rtl/adxl362_spi_slave.sv
// adxl362_spi_slave: SPI mode-0 slave that models the ADXL362 register map.
// SCLK is the only clock. MOSI is sampled on rising edges and MISO is launched
// on falling edges. Acceleration and temperature samples are fixed parameters.
module adxl362_spi_slave #(
  parameter logic [11:0] X_VAL = 12'h010,
  parameter logic [11:0] Y_VAL = 12'h020,
  parameter logic [11:0] Z_VAL = 12'h3F0,
  parameter logic [11:0] T_VAL = 12'h000
) (
  input  logic SCLK,
  input  logic reset,
  input  logic nCS,
  input  logic MOSI,
  output logic MISO,
  output logic INT1,
  output logic INT2
);

  localparam logic [7:0] CMD_WRITE       = 8'h0A;
  localparam logic [7:0] CMD_READ        = 8'h0B;
  localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
  localparam logic [7:0] SOFT_RESET_KEY  = 8'h52;
  localparam logic [7:0] CFG_FIRST       = 8'h20;
  localparam logic [7:0] CFG_LAST        = 8'h2E;
  localparam int         CFG_COUNT       = 15;
  // Index of each R/W register, counted from address 0x20.
  localparam int         IDX_INTMAP1     = 10;
  localparam int         IDX_INTMAP2     = 11;
  localparam int         IDX_FILTER_CTL  = 12;
  localparam int         IDX_POWER_CTL   = 13;

  // Byte position inside a transaction: command, address, then data bytes.
  typedef enum logic [1:0] {
    PH_CMD  = 2'd0,
    PH_ADDR = 2'd1,
    PH_DATA = 2'd2
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_q;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [7:0]  tx_q;
  logic        miso_q;

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        wr_en;
  logic        load_en;
  logic        soft_rst;
  logic        cfg_hit;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_val;
  logic [7:0]  load_val;
  logic [7:0]  status;
  logic [7:0]  cfg_q [CFG_COUNT];

  // Reset value of each R/W register. Only FILTER_CTL has a non-zero default.
  function automatic logic [7:0] cfg_default(input int idx);
    return (idx == IDX_FILTER_CTL) ? 8'h13 : 8'h00;
  endfunction

  // Sign-extended upper nibble of a 12-bit sample, which forms the high data byte.
  function automatic logic [7:0] sample_hi(input logic [11:0] v);
    return {{4{v[11]}}, v[11:8]};
  endfunction

  // The byte that the current rising edge completes (seven earlier bits plus MOSI).
  assign rx_byte   = {rx_q, MOSI};
  assign byte_done = (bit_cnt_q == 3'd7);

  // Byte-phase register. A high nCS drops it back to the command byte.
  always_ff @(posedge SCLK or posedge reset or posedge nCS) begin
    if (reset) begin
      phase_q <= PH_CMD;
    end else if (nCS) begin
      phase_q <= PH_CMD;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next-phase logic: advance on each completed byte, then stay in the data phase.
  always_comb begin
    phase_d = phase_q;
    if (byte_done) begin
      case (phase_q)
        PH_CMD:  phase_d = PH_ADDR;
        PH_ADDR: phase_d = PH_DATA;
        default: phase_d = PH_DATA;
      endcase
    end
  end

  // Phase decode: register write strobe, shift-register reload, and read address.
  // At the end of the address byte the read address is the byte just received.
  // At the end of a data byte it is the incremented address.
  always_comb begin
    wr_en    = 1'b0;
    load_en  = 1'b0;
    rd_addr  = addr_q + 8'd1;
    load_val = 8'h00;
    case (phase_q)
      PH_ADDR: begin
        load_en = byte_done;
        rd_addr = rx_byte;
      end
      PH_DATA: begin
        load_en = byte_done;
        wr_en   = byte_done && (cmd_q == CMD_WRITE);
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
    if (cmd_q == CMD_READ) begin
      load_val = rd_val;
    end
  end

  assign soft_rst = wr_en && (addr_q == ADDR_SOFT_RESET) && (rx_byte == SOFT_RESET_KEY);
  assign cfg_hit  = (addr_q >= CFG_FIRST) && (addr_q <= CFG_LAST);

  // Rising-edge transaction datapath: bit counter, input shifter, command and
  // address latches, and the outgoing shift register. nCS high clears all of it,
  // so an aborted partial byte never completes.
  always_ff @(posedge SCLK or posedge reset or posedge nCS) begin
    if (reset) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      tx_q      <= 8'h00;
    end else if (nCS) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      tx_q      <= 8'h00;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_q      <= {rx_q[5:0], MOSI};
      if (byte_done && phase_q == PH_CMD) begin
        cmd_q <= rx_byte;
      end
      if (byte_done && phase_q == PH_ADDR) begin
        addr_q <= rx_byte;
      end else if (byte_done && phase_q == PH_DATA) begin
        addr_q <= addr_q + 8'd1;
      end
      if (load_en) begin
        tx_q <= load_val;
      end else begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
    end
  end

  // Falling-edge launch of the outgoing MSB.
  always_ff @(negedge SCLK or posedge reset or posedge nCS) begin
    if (reset) begin
      miso_q <= 1'b0;
    end else if (nCS) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= tx_q[7];
    end
  end

  assign MISO = miso_q & ~nCS;

  // R/W register bank at 0x20-0x2E. A write of the key to SOFT_RESET restores
  // the defaults. SOFT_RESET itself is not stored.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CFG_COUNT; i++) begin
        cfg_q[i] <= cfg_default(i);
      end
    end else if (soft_rst) begin
      for (int i = 0; i < CFG_COUNT; i++) begin
        cfg_q[i] <= cfg_default(i);
      end
    end else if (wr_en && cfg_hit) begin
      cfg_q[addr_q[3:0]] <= rx_byte;
    end
  end

  // STATUS: AWAKE is always set. DATA_READY is set while measuring (POWER_CTL mode 2'b10).
  always_comb begin
    status    = 8'h40;
    status[0] = (cfg_q[IDX_POWER_CTL][1:0] == 2'b10);
  end

  // Register read mux. Unimplemented addresses read back 0x00.
  always_comb begin
    rd_val = 8'h00;
    case (rd_addr)
      8'h00:   rd_val = 8'hAD;
      8'h01:   rd_val = 8'h1D;
      8'h02:   rd_val = 8'hF2;
      8'h03:   rd_val = 8'h01;
      8'h08:   rd_val = X_VAL[11:4];
      8'h09:   rd_val = Y_VAL[11:4];
      8'h0A:   rd_val = Z_VAL[11:4];
      8'h0B:   rd_val = status;
      8'h0E:   rd_val = X_VAL[7:0];
      8'h0F:   rd_val = sample_hi(X_VAL);
      8'h10:   rd_val = Y_VAL[7:0];
      8'h11:   rd_val = sample_hi(Y_VAL);
      8'h12:   rd_val = Z_VAL[7:0];
      8'h13:   rd_val = sample_hi(Z_VAL);
      8'h14:   rd_val = T_VAL[7:0];
      8'h15:   rd_val = sample_hi(T_VAL);
      default: begin
        if (rd_addr >= CFG_FIRST && rd_addr <= CFG_LAST) begin
          rd_val = cfg_q[rd_addr[3:0]];
        end
      end
    endcase
  end

  // Interrupt pins. They are combinational from STATUS and INTMAPx, and bit 7 inverts the polarity.
  always_comb begin
    INT1 = (|(status[6:0] & cfg_q[IDX_INTMAP1][6:0])) ^ cfg_q[IDX_INTMAP1][7];
    INT2 = (|(status[6:0] & cfg_q[IDX_INTMAP2][6:0])) ^ cfg_q[IDX_INTMAP2][7];
  end

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// tb_adxl362_spi_slave: drives SPI mode-0 transactions into adxl362_spi_slave
// and compares MISO bytes and interrupt pins against a register-map model.
module tb_adxl362_spi_slave;

  localparam logic [11:0] X_V = 12'h010;
  localparam logic [11:0] Y_V = 12'h020;
  localparam logic [11:0] Z_V = 12'h3F0;
  localparam logic [11:0] T_V = 12'h000;

  logic SCLK  = 1'b0;
  logic reset = 1'b0;
  logic nCS   = 1'b1;
  logic MOSI  = 1'b0;
  logic MISO;
  logic INT1;
  logic INT2;

  int n_tests = 0;
  int n_fail  = 0;
  int txn_no  = 0;

  logic [7:0] m_cfg  [256];
  logic [7:0] tx_buf [32];
  logic [7:0] rx_buf [32];

  adxl362_spi_slave #(
    .X_VAL(X_V),
    .Y_VAL(Y_V),
    .Z_VAL(Z_V),
    .T_VAL(T_V)
  ) dut (
    .SCLK (SCLK),
    .reset(reset),
    .nCS  (nCS),
    .MOSI (MOSI),
    .MISO (MISO),
    .INT1 (INT1),
    .INT2 (INT2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] lo_byte(input logic [11:0] v);
    return 8'(v & 12'h0FF);
  endfunction

  function automatic logic [7:0] hi_byte(input logic [11:0] v);
    int s;
    s = (v >= 12'd2048) ? (int'(v) - 4096) : int'(v);
    return 8'((s >>> 8) & 255);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_cfg[i] = 8'h00;
    m_cfg[8'h2C] = 8'h13;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h03: return 8'h01;
      8'h08: return 8'(X_V >> 4);
      8'h09: return 8'(Y_V >> 4);
      8'h0A: return 8'(Z_V >> 4);
      8'h0B: return (m_cfg[8'h2D][1:0] == 2'b10) ? 8'h41 : 8'h40;
      8'h0E: return lo_byte(X_V);
      8'h0F: return hi_byte(X_V);
      8'h10: return lo_byte(Y_V);
      8'h11: return hi_byte(Y_V);
      8'h12: return lo_byte(Z_V);
      8'h13: return hi_byte(Z_V);
      8'h14: return lo_byte(T_V);
      8'h15: return hi_byte(T_V);
      default: return (a >= 8'h20 && a <= 8'h2E) ? m_cfg[a] : 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h1F && d == 8'h52) m_reset();
    else if (a >= 8'h20 && a <= 8'h2E) m_cfg[a] = d;
  endtask

  function automatic logic m_int(input logic [7:0] map);
    logic [7:0] st;
    st = m_read(8'h0B);
    return ((st & map & 8'h7F) != 8'h00) ^ map[7];
  endfunction

  // ---------------- SPI driver ----------------
  // MOSI is set while SCLK is low. MISO is sampled just before the rising edge.
  task automatic spi_bit(input logic b, output logic r);
    MOSI = b;
    #4 r = MISO;
    #1 SCLK = 1'b1;
    #5 SCLK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  // Full transaction using tx_buf[2..] as data and checking every returned byte.
  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] addr, input int ndata);
    logic [7:0] a;
    logic [7:0] exp;
    logic [7:0] rb;
    tx_buf[0] = cmd;
    tx_buf[1] = addr;
    nCS = 1'b0;
    #5;
    for (int b = 0; b < ndata + 2; b++) begin
      spi_byte(tx_buf[b], rb);
      rx_buf[b] = rb;
    end
    #5 nCS = 1'b1;
    #10;
    txn_no++;
    $display("[TB] txn %0d cmd=%02h addr=%02h data_bytes=%0d first_rx=%02h",
             txn_no, cmd, addr, ndata, (ndata > 0) ? rx_buf[2] : 8'h00);
    check("cmd_byte_miso", {24'd0, rx_buf[0]}, 32'd0);
    check("addr_byte_miso", {24'd0, rx_buf[1]}, 32'd0);
    for (int k = 0; k < ndata; k++) begin
      a   = addr + 8'(k);
      exp = (cmd == 8'h0B) ? m_read(a) : 8'h00;
      check($sformatf("data_c%02h_a%02h", cmd, a), {24'd0, rx_buf[k + 2]}, {24'd0, exp});
      if (cmd == 8'h0A) m_write(a, tx_buf[k + 2]);
    end
    check("int1", {31'd0, INT1}, {31'd0, m_int(m_cfg[8'h2A])});
    check("int2", {31'd0, INT2}, {31'd0, m_int(m_cfg[8'h2B])});
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] d);
    tx_buf[2] = d;
    do_txn(8'h0A, a, 1);
  endtask

  task automatic rdn(input logic [7:0] a, input int n);
    for (int k = 0; k < n; k++) tx_buf[k + 2] = 8'h00;
    do_txn(8'h0B, a, n);
  endtask

  initial begin
    logic [7:0] rb;
    logic       r;
    logic [7:0] cmd;
    logic [7:0] addr;
    int         nd;

    m_reset();
    reset = 1'b1;
    #3;
    check("reset_miso", {31'd0, MISO}, 32'd0);
    check("reset_int1", {31'd0, INT1}, 32'd0);
    check("reset_int2", {31'd0, INT2}, 32'd0);
    #10 reset = 1'b0;
    #10;

    // ID burst
    rdn(8'h00, 4);
    check("devid_ad", {24'd0, rx_buf[2]}, 32'hAD);
    check("partid", {24'd0, rx_buf[4]}, 32'hF2);

    // DATA_READY follows POWER_CTL
    wr1(8'h2D, 8'h02);
    rdn(8'h0B, 1);
    check("status_meas", {24'd0, rx_buf[2]}, 32'h41);
    wr1(8'h2D, 8'h00);
    rdn(8'h0B, 1);
    check("status_stby", {24'd0, rx_buf[2]}, 32'h40);

    // sample registers
    rdn(8'h0E, 6);
    check("zdata_h", {24'd0, rx_buf[7]}, 32'h03);
    rdn(8'h08, 1);

    // interrupts
    wr1(8'h2D, 8'h02);
    wr1(8'h2A, 8'h01);
    check("int1_on", {31'd0, INT1}, 32'd1);
    wr1(8'h2A, 8'h81);
    check("int1_inv", {31'd0, INT1}, 32'd0);

    // soft reset
    wr1(8'h2C, 8'h55);
    rdn(8'h2C, 1);
    wr1(8'h1F, 8'h52);
    rdn(8'h2C, 1);
    check("filter_default", {24'd0, rx_buf[2]}, 32'h13);
    rdn(8'h1F, 1);

    // aborted write: 4 bits of a data byte, then nCS high
    nCS = 1'b0;
    #5;
    spi_byte(8'h0A, rb);
    spi_byte(8'h2E, rb);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    #5 nCS = 1'b1;
    #10;
    rdn(8'h2E, 1);
    check("abort_selftest", {24'd0, rx_buf[2]}, 32'h00);

    // address wrap 0xFF -> 0x00
    rdn(8'hFE, 4);

    // randomized transactions
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0: addr = 8'($urandom_range(0, 8'h30));
        1: addr = 8'($urandom_range(8'hFA, 8'hFF));
        2: addr = 8'($urandom_range(8'h1F, 8'h2E));
        default: addr = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'h0A;
        4, 5, 6, 7: cmd = 8'h0B;
        8:          cmd = 8'h0D;
        default:    cmd = 8'($urandom_range(0, 255));
      endcase
      nd = $urandom_range(0, 6);
      for (int k = 0; k < nd; k++) begin
        tx_buf[k + 2] = ($urandom_range(0, 7) == 0) ? 8'h52 : 8'($urandom_range(0, 255));
      end
      do_txn(cmd, addr, nd);
    end

    // reset in the middle of a read: MISO shows 0xAD's MSB, then drops at once
    wr1(8'h2B, 8'h40);
    nCS = 1'b0;
    #5;
    spi_byte(8'h0B, rb);
    spi_byte(8'h00, rb);
    #2;
    check("midread_msb", {31'd0, MISO}, 32'd1);
    reset = 1'b1;
    #1;
    check("midread_reset_miso", {31'd0, MISO}, 32'd0);
    m_reset();
    #5 reset = 1'b0;
    nCS = 1'b1;
    #10;
    check("post_reset_int2", {31'd0, INT2}, 32'd0);
    rdn(8'h2B, 1);
    rdn(8'h2C, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
